// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared types for the lockstep checker.
//   bundle_t : 104-bit core-output bundle, LSB first:
//              instr_req, instr_addr, data_req, data_we, data_be,
//              data_addr, data_wdata, core_busy
//   field_e  : 3-bit mismatch field code (lower code = higher priority)
//   state_e  : checker FSM states
//   field_value() : low 32 bits of one field, single bits zero-extended
package lockstep_pkg;

  localparam int unsigned BUNDLE_W = 104;

  typedef struct packed {
    logic        core_busy;
    logic [31:0] data_wdata;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic        data_we;
    logic        data_req;
    logic [31:0] instr_addr;
    logic        instr_req;
  } bundle_t;

  typedef enum logic [2:0] {
    F_INSTR_REQ  = 3'd0,
    F_INSTR_ADDR = 3'd1,
    F_DATA_REQ   = 3'd2,
    F_DATA_ADDR  = 3'd3,
    F_DATA_BE_WE = 3'd4,
    F_DATA_WDATA = 3'd5,
    F_CORE_BUSY  = 3'd6
  } field_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_CHECK  = 2'd2
  } state_e;

  function automatic logic [31:0] field_value(input bundle_t x, input field_e f);
    case (f)
      F_INSTR_REQ:  field_value = {31'b0, x.instr_req};
      F_INSTR_ADDR: field_value = x.instr_addr;
      F_DATA_REQ:   field_value = {31'b0, x.data_req};
      F_DATA_ADDR:  field_value = x.data_addr;
      F_DATA_BE_WE: field_value = {27'b0, x.data_be, x.data_we};
      F_DATA_WDATA: field_value = x.data_wdata;
      F_CORE_BUSY:  field_value = {31'b0, x.core_busy};
      default:      field_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// lockstep_delay_line: DELAY-deep, W-bit shift register, async active-low
// reset clears every stage. DELAY=0 is a combinational pass-through.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   din   : input word
//   dout  : din delayed by DELAY cycles
module lockstep_delay_line #(
  parameter int unsigned DELAY = 2,
  parameter int unsigned W     = 104
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = din;
    end else begin : g_regs
      logic [W-1:0] stage [DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DELAY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: compares the cls1 bundle, re-aligned by DELAY cycles,
// against the cls2 bundle and reports mismatches to the safety controller.
//   clk, rst          : clock, asynchronous active-low reset
//   enable_i          : checking enabled (drop -> IDLE, re-enable -> WARMUP)
//   clear_i           : clears err_o, err_field_o, err_count_o, alarm_o
//   cls1_i, cls2_i    : 104-bit core bundles (see lockstep_pkg::bundle_t)
//   mismatch_o        : one-cycle pulse per mismatching compare
//   err_o             : sticky error
//   err_field_o       : field code of first mismatch since clear
//   err_count_o       : saturating mismatch count
//   alarm_o           : sticky, err_count_o >= ERR_THRESH
// Optional macro LOCKSTEP_CHK_CAPTURE_EN adds cap1_o/cap2_o, the low 32 bits
// of the first mismatching field from cls1 (delayed) and cls2.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int unsigned DELAY      = 2,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [BUNDLE_W-1:0] cls1_i,
  input  logic [BUNDLE_W-1:0] cls2_i,
  output logic                mismatch_o,
  output logic                err_o,
  output logic [2:0]          err_field_o,
  output logic [CNT_W-1:0]    err_count_o,
  output logic                alarm_o
`ifdef LOCKSTEP_CHK_CAPTURE_EN
  ,
  output logic [31:0]         cap1_o,
  output logic [31:0]         cap2_o
`endif
);

  localparam logic [3:0]       WARM_LAST = (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(ERR_THRESH);

  logic [BUNDLE_W-1:0] cls1_d;
  bundle_t a, b;

  lockstep_delay_line #(.DELAY(DELAY), .W(BUNDLE_W)) u_delay (
    .clk   (clk),
    .rst_n (rst),
    .din   (cls1_i),
    .dout  (cls1_d)
  );

  assign a = bundle_t'(cls1_d);
  assign b = bundle_t'(cls2_i);

  // FSM
  state_e     state_q, state_d;
  logic [3:0] warm_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      warm_cnt <= '0;
    end else begin
      state_q  <= state_d;
      warm_cnt <= (state_q == S_WARMUP && state_d == S_WARMUP) ? warm_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable_i) state_d = S_WARMUP;
      S_WARMUP: if (warm_cnt == WARM_LAST) state_d = S_CHECK;
      S_CHECK:  state_d = S_CHECK;
      default:  state_d = S_IDLE;
    endcase
    if (!enable_i) state_d = S_IDLE;
  end

  // Compare: if/else chain ordered by field code so the lowest code wins.
  logic   mm_raw, mm;
  field_e code;
  logic   both_ireq, both_dreq, both_we;

  always_comb begin
    mm_raw    = 1'b0;
    code      = F_INSTR_REQ;
    both_ireq = a.instr_req & b.instr_req;
    both_dreq = a.data_req & b.data_req;
    both_we   = both_dreq & a.data_we & b.data_we;
    if (a.instr_req != b.instr_req) begin
      mm_raw = 1'b1; code = F_INSTR_REQ;
    end else if (both_ireq && a.instr_addr != b.instr_addr) begin
      mm_raw = 1'b1; code = F_INSTR_ADDR;
    end else if (a.data_req != b.data_req) begin
      mm_raw = 1'b1; code = F_DATA_REQ;
    end else if (both_dreq && a.data_addr != b.data_addr) begin
      mm_raw = 1'b1; code = F_DATA_ADDR;
    end else if (both_dreq && {a.data_be, a.data_we} != {b.data_be, b.data_we}) begin
      mm_raw = 1'b1; code = F_DATA_BE_WE;
    end else if (both_we && a.data_wdata != b.data_wdata) begin
      mm_raw = 1'b1; code = F_DATA_WDATA;
    end else if (a.core_busy != b.core_busy) begin
      mm_raw = 1'b1; code = F_CORE_BUSY;
    end
    // enable_i gates directly so compares stop in the same cycle it drops
    mm = mm_raw & enable_i & (state_q == S_CHECK);
  end

  // Clear is applied first, then a coincident mismatch on top of it.
  logic [CNT_W-1:0] cnt_base, cnt_inc;
  logic             capture;

  assign cnt_base = clear_i ? '0 : err_count_o;
  assign cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
  assign capture  = mm & (clear_i | ~err_o);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_o  <= 1'b0;
      err_o       <= 1'b0;
      err_field_o <= '0;
      err_count_o <= '0;
      alarm_o     <= 1'b0;
    end else begin
      mismatch_o <= mm;
      if (mm) begin
        err_o       <= 1'b1;
        err_count_o <= cnt_inc;
        alarm_o     <= (alarm_o & ~clear_i) | (cnt_inc >= THRESH);
        if (capture) err_field_o <= code;
      end else if (clear_i) begin
        err_o       <= 1'b0;
        err_field_o <= '0;
        err_count_o <= '0;
        alarm_o     <= 1'b0;
      end
    end
  end

`ifdef LOCKSTEP_CHK_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap1_o <= '0;
      cap2_o <= '0;
    end else if (capture) begin
      cap1_o <= field_value(a, code);
      cap2_o <= field_value(b, code);
    end else if (clear_i) begin
      cap1_o <= '0;
      cap2_o <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// tb_lockstep_checker: directed self-checking bench for lockstep_checker
// (DELAY=2, ERR_THRESH=4, CNT_W=4 so saturation is reachable quickly).
// cls2 is driven as the cls1 value from two steps earlier, optionally XORed
// with a fault mask for one step.
module tb_lockstep_checker;
  import lockstep_pkg::*;

  localparam int unsigned DELAY = 2;
  localparam int unsigned TH    = 4;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [103:0]  cls1_i = '0;
  logic [103:0]  cls2_i = '0;
  logic          mismatch_o, err_o, alarm_o;
  logic [2:0]    err_field_o;
  logic [CW-1:0] err_count_o;
`ifdef LOCKSTEP_CHK_CAPTURE_EN
  logic [31:0]   cap1_o, cap2_o;
`endif

  int checks = 0;
  int errors = 0;
  bundle_t p1 = '0, p2 = '0;
  bundle_t Z = '0;

  lockstep_checker #(.DELAY(DELAY), .ERR_THRESH(TH), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .clear_i     (clear_i),
    .cls1_i      (cls1_i),
    .cls2_i      (cls2_i),
    .mismatch_o  (mismatch_o),
    .err_o       (err_o),
    .err_field_o (err_field_o),
    .err_count_o (err_count_o),
    .alarm_o     (alarm_o)
`ifdef LOCKSTEP_CHK_CAPTURE_EN
    ,
    .cap1_o      (cap1_o),
    .cap2_o      (cap2_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, wait for the edge, sample 1 time unit later.
  task automatic step(input bundle_t a, input bundle_t xm, input logic en, input logic clr);
    enable_i = en;
    clear_i  = clr;
    cls1_i   = a;
    cls2_i   = p2 ^ xm;
    @(posedge clk);
    #1;
    p2 = p1;
    p1 = a;
    clear_i = 1'b0;
  endtask

  // Drive a for three steps; the third sees cls1_d == a and cls2 == a ^ xm.
  task automatic inject(input bundle_t a, input bundle_t xm, input logic clr);
    step(a, Z, 1'b1, 1'b0);
    step(a, Z, 1'b1, 1'b0);
    step(a, xm, 1'b1, clr);
  endtask

  function automatic bundle_t gen(input int n);
    bundle_t g;
    g = '0;
    g.instr_req  = n[0];
    g.instr_addr = 32'(n) * 32'd4;
    g.data_req   = n[1];
    g.data_we    = n[2];
    g.data_be    = n[5:2];
    g.data_addr  = 32'h1000 + 32'(n);
    g.data_wdata = 32'(n) * 32'h01010101;
    g.core_busy  = n[3];
    return g;
  endfunction

  initial begin
    bundle_t a, xm, xm2;
    int mm_seen;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mismatch", 32'(mismatch_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_field", 32'(err_field_o), 0);
    chk("rst_count", 32'(err_count_o), 0);
    chk("rst_alarm", 32'(alarm_o), 0);
    rst = 1'b1;

    // identical streams
    mm_seen = 0;
    for (int n = 0; n < 1000; n++) begin
      step(gen(n), Z, 1'b1, 1'b0);
      if (mismatch_o) mm_seen++;
    end
    chk("ident_mm_seen", 32'(mm_seen), 0);
    chk("ident_count", 32'(err_count_o), 0);
    chk("ident_err", 32'(err_o), 0);

    // single instr_req fault
    a = gen(7);
    xm = Z; xm.instr_req = 1'b1;
    inject(a, xm, 1'b0);
    chk("fault_mm", 32'(mismatch_o), 1);
    chk("fault_field", 32'(err_field_o), 0);
    chk("fault_count", 32'(err_count_o), 1);
    chk("fault_err", 32'(err_o), 1);
    step(a, Z, 1'b1, 1'b0);
    chk("fault_pulse_end", 32'(mismatch_o), 0);
    chk("fault_count_hold", 32'(err_count_o), 1);

    // clear, then wdata gated by data_we
    step(a, Z, 1'b1, 1'b1);
    chk("clr_err", 32'(err_o), 0);
    chk("clr_count", 32'(err_count_o), 0);
    a = Z; a.data_req = 1'b1; a.data_wdata = 32'h11;
    xm = Z; xm.data_wdata = 32'h01;
    inject(a, xm, 1'b0);
    chk("wdata_we0_mm", 32'(mismatch_o), 0);
    chk("wdata_we0_err", 32'(err_o), 0);
    a.data_we = 1'b1;
    inject(a, xm, 1'b0);
    chk("wdata_we1_mm", 32'(mismatch_o), 1);
    chk("wdata_we1_field", 32'(err_field_o), 5);
    chk("wdata_we1_count", 32'(err_count_o), 1);
`ifdef LOCKSTEP_CHK_CAPTURE_EN
    chk("cap1", cap1_o, 32'h11);
    chk("cap2", cap2_o, 32'h10);
`endif

    // data_addr ignored without data_req; priority picks lowest code
    step(a, Z, 1'b1, 1'b1);
    a = Z; a.data_addr = 32'hdead;
    xm = Z; xm.data_addr = 32'h1;
    inject(a, xm, 1'b0);
    chk("daddr_noreq_mm", 32'(mismatch_o), 0);
    a = Z; a.instr_req = 1'b1;
    xm = Z; xm.instr_addr = 32'h4; xm.core_busy = 1'b1;
    inject(a, xm, 1'b0);
    chk("prio_mm", 32'(mismatch_o), 1);
    chk("prio_field", 32'(err_field_o), 1);

    // threshold alarm
    step(a, Z, 1'b1, 1'b1);
    chk("th_clr_alarm", 32'(alarm_o), 0);
    a = Z;
    xm = Z; xm.instr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inject(a, xm, 1'b0);
      chk("th_count", 32'(err_count_o), 32'(i + 1));
      chk("th_alarm", 32'(alarm_o), (i == 3) ? 1 : 0);
    end
    chk("th_field", 32'(err_field_o), 0);
    // clear coincident with 5th mismatch
    xm2 = Z; xm2.data_req = 1'b1;
    inject(a, xm2, 1'b1);
    chk("clrmm_mm", 32'(mismatch_o), 1);
    chk("clrmm_count", 32'(err_count_o), 1);
    chk("clrmm_alarm", 32'(alarm_o), 0);
    chk("clrmm_err", 32'(err_o), 1);
    chk("clrmm_field", 32'(err_field_o), 2);

    // saturation at all-ones
    step(a, Z, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(a, xm, 1'b1, 1'b0);
    chk("sat_count", 32'(err_count_o), 15);
    chk("sat_alarm", 32'(alarm_o), 1);
    chk("sat_mm", 32'(mismatch_o), 1);

    // enable drop and re-warmup
    step(a, Z, 1'b1, 1'b1);
    step(a, xm, 1'b1, 1'b0);
    chk("en_pre_count", 32'(err_count_o), 1);
    step(a, xm, 1'b0, 1'b0);
    chk("en_off_mm", 32'(mismatch_o), 0);
    chk("en_off_err", 32'(err_o), 1);
    step(a, xm, 1'b0, 1'b0);
    chk("en_off_count", 32'(err_count_o), 1);
    step(a, xm, 1'b1, 1'b0);
    chk("re_idle_mm", 32'(mismatch_o), 0);
    step(a, xm, 1'b1, 1'b0);
    chk("re_warm1_mm", 32'(mismatch_o), 0);
    step(a, xm, 1'b1, 1'b0);
    chk("re_warm2_mm", 32'(mismatch_o), 0);
    chk("re_warm_count", 32'(err_count_o), 1);
    step(a, xm, 1'b1, 1'b0);
    chk("re_check_mm", 32'(mismatch_o), 1);
    chk("re_check_count", 32'(err_count_o), 2);
    step(a, xm, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(err_count_o), 3);

    // asynchronous reset mid-cycle
    #3;
    rst = 1'b0;
    #1;
    chk("arst_mismatch", 32'(mismatch_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_field", 32'(err_field_o), 0);
    chk("arst_count", 32'(err_count_o), 0);
    chk("arst_alarm", 32'(alarm_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
